dds_par_rx: RTL
===============

// Module: dds_par_rx
// PURPOSE
//  DDS-side receiver for the 6-bit-address / 8-bit-data parallel config port driven by the DDS config writer.
//  Decodes byte writes into a shadow register file and transfers shadow to active on the update strobe.
//  Used as a synthesizable register model in the DDS subsystem and as the checker end of the config bus.
//  Exposes decoded active words (FTW, PTW, DFW, ramp rate, mode, PLL) plus write/error status.
// PARAMETERS
//  CNT_W    8   width of the accepted-write counter WR_CNT (saturating)
// PORTS
//  CLK       in   1   system clock; every input is synchronous to it
//  RESET_N   in   1   asynchronous active-low reset
//  AIN       in   6   register address from the writer
//  DIN       in   8   write data from the writer
//  WRITE     in   1   write strobe; a byte is accepted on its rising edge
//  DDS_RST   in   1   DDS master reset, active high, level
//  UPDATE    in   1   update strobe; shadow-to-active copy on its rising edge
//  FTW1      out  48  active frequency tuning word 1
//  FTW2      out  48  active frequency tuning word 2
//  PTW1      out  14  active phase word 1
//  PTW2      out  14  active phase word 2
//  DFW       out  48  active delta-frequency word
//  RAMPRATE  out  20  active ramp-rate clock word
//  MODE      out  3   active mode field
//  TRIANGLE  out  1   active triangle-sweep enable
//  PLLRANGE  out  1   active PLL range bit
//  PLLEN     out  1   active PLL enable
//  CLKMULT   out  5   active reference clock multiplier
//  CTRL20    out  8   active raw byte at address 0x20
//  PENDING   out  1   shadow written since last update
//  WR_CNT    out  CNT_W  count of writes accepted since last update
//  ADDR_ERR  out  1   sticky: write to an unmapped address
//  UPD_DONE  out  1   one-cycle pulse in the cycle after an active copy
// BEHAVIOUR
//  Reset (RESET_N=0): all outputs, shadow regs, edge-detect flops and the FSM go to 0 / RST.
//  Edge detect: WRITE and UPDATE are each registered once. wr_evt = WRITE & ~WRITE_q; upd_evt = UPDATE & ~UPDATE_q.
//  On wr_evt, AIN/DIN of that same cycle are decoded into shadow. No input synchronizers: inputs are on CLK.
//  Map (addr: field, MSB first):
//    0x00 PTW[13:8] from DIN[5:0]; 0x01 PTW1[7:0]; 0x02 PTW2[13:8] from DIN[5:0]; 0x03 PTW2[7:0].
//    0x04..0x09 FTW1[47:40]..FTW1[7:0]; 0x0A..0x0F FTW2[47:40]..FTW2[7:0].
//    0x10..0x15 DFW[47:40]..DFW[7:0]; 0x1A RAMPRATE[19:16] from DIN[3:0]; 0x1B [15:8]; 0x1C [7:0].
//    0x1E: DIN[6] PLLRANGE, DIN[5] PLLEN, DIN[4:0] CLKMULT; 0x1F: DIN[6:4] MODE, DIN[2] TRIANGLE.
//    0x20: full byte to CTRL20. Unused DIN bits are discarded.
//    Unmapped (0x16-0x19, 0x1D, 0x21-0x3F): shadow unchanged, ADDR_ERR<=1, not counted in WR_CNT.
//  Each mapped write increments WR_CNT, saturating at 2^CNT_W-1. Rewriting an address overwrites it.
//  FSM:
//    RST: entered while DDS_RST=1. Shadow and active cleared to 0, WR_CNT=0, PENDING=0, writes ignored.
//         Exits to IDLE the cycle after DDS_RST falls.
//    IDLE: no mapped write pending. On a mapped wr_evt go to DIRTY.
//    DIRTY: PENDING=1. On upd_evt go to IDLE.
//  upd_evt in IDLE or DIRTY (never in RST):
//    Active copies the shadow as it stood before this cycle; WR_CNT<=0; UPD_DONE=1 the next cycle.
//  Update in IDLE still copies and pulses UPD_DONE.
//  Same-cycle wr_evt and upd_evt: the copy uses the old shadow; the write lands in shadow.
//    WR_CNT<=1 and the FSM goes to DIRTY, so the write is held for the next update.
//  DDS_RST wins over wr_evt/upd_evt in the same cycle. ADDR_ERR is cleared only by RESET_N or DDS_RST.
//  Async RESET_N mid-sequence discards the partial shadow. No output changes except on CLK edges or on reset.
// TESTING
//  Reset: RESET_N low, then high -> all outputs 0, PENDING=0, UPD_DONE=0.
//  FTW1 load: write 0x04..0x09 = 12,34,56,78,9A,BC.
//    Before update: FTW1=0, PENDING=1, WR_CNT=6.
//    After UPDATE rise: FTW1=48'h123456789ABC, UPD_DONE one cycle, WR_CNT=0.
//  Control: 0x1E=0x64, 0x1F=0x24, update -> PLLRANGE=1, PLLEN=1, CLKMULT=4, MODE=2, TRIANGLE=1.
//  PTW2: 0x02=0xFF, 0x03=0x01, update -> PTW2=14'h3F01.
//  Error: write 0x17=0x55 -> ADDR_ERR=1, WR_CNT unchanged, shadow unchanged; DDS_RST pulse clears ADDR_ERR.
//  Collision: wr_evt(0x09=0xAA) in the same cycle as upd_evt -> FTW1[7:0] keeps its old value, PENDING=1.
//    Next update -> FTW1[7:0]=0xAA.

Source files
------------

// File: rtl/dds_par_rx.sv
// dds_par_rx: parallel config-port receiver with shadow/active register file and update transfer.
module dds_par_rx #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [5:0]       AIN,
    input  logic [7:0]       DIN,
    input  logic             WRITE,
    input  logic             DDS_RST,
    input  logic             UPDATE,
    output logic [47:0]      FTW1,
    output logic [47:0]      FTW2,
    output logic [13:0]      PTW1,
    output logic [13:0]      PTW2,
    output logic [47:0]      DFW,
    output logic [19:0]      RAMPRATE,
    output logic [2:0]       MODE,
    output logic             TRIANGLE,
    output logic             PLLRANGE,
    output logic             PLLEN,
    output logic [4:0]       CLKMULT,
    output logic [7:0]       CTRL20,
    output logic             PENDING,
    output logic [CNT_W-1:0] WR_CNT,
    output logic             ADDR_ERR,
    output logic             UPD_DONE
);
    typedef enum logic [1:0] {RST, IDLE, DIRTY} state_t;
    typedef struct packed {
        logic [13:0] ptw1;
        logic [13:0] ptw2;
        logic [47:0] ftw1;
        logic [47:0] ftw2;
        logic [47:0] dfw;
        logic [19:0] ramp;
        logic [2:0]  mode;
        logic        triangle;
        logic        pllrange;
        logic        pllen;
        logic [4:0]  clkmult;
        logic [7:0]  ctrl20;
    } regs_t;

    state_t state, state_nxt;
    regs_t  shadow, active, shadow_wr;
    logic   write_q, update_q, wr_evt, upd_evt, mapped, clr, wr_ok, upd_ok;

    assign wr_evt  = WRITE & ~write_q;
    assign upd_evt = UPDATE & ~update_q;
    assign wr_ok   = wr_evt & mapped & ~clr;
    assign upd_ok  = upd_evt & ~clr;

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) state <= RST;
        else state <= state_nxt;

    // a write in the update cycle keeps the FSM dirty for the following update
    always_comb
        state_nxt = DDS_RST ? RST : state == RST ? IDLE : wr_ok ? DIRTY : upd_ok ? IDLE : state;

    always_comb begin
        clr     = DDS_RST | (state == RST);
        PENDING = state == DIRTY;
    end

    always_comb begin
        shadow_wr = shadow;
        mapped    = 1'b1;
        case (AIN) inside
            6'h00:          shadow_wr.ptw1[13:8] = DIN[5:0];
            6'h01:          shadow_wr.ptw1[7:0]  = DIN;
            6'h02:          shadow_wr.ptw2[13:8] = DIN[5:0];
            6'h03:          shadow_wr.ptw2[7:0]  = DIN;
            [6'h04:6'h09]:  shadow_wr.ftw1[8*(9-int'(AIN)) +: 8]  = DIN;
            [6'h0A:6'h0F]:  shadow_wr.ftw2[8*(15-int'(AIN)) +: 8] = DIN;
            [6'h10:6'h15]:  shadow_wr.dfw[8*(21-int'(AIN)) +: 8]  = DIN;
            6'h1A:          shadow_wr.ramp[19:16] = DIN[3:0];
            6'h1B:          shadow_wr.ramp[15:8]  = DIN;
            6'h1C:          shadow_wr.ramp[7:0]   = DIN;
            6'h1E:          {shadow_wr.pllrange, shadow_wr.pllen, shadow_wr.clkmult} = DIN[6:0];
            6'h1F:          {shadow_wr.mode, shadow_wr.triangle} = {DIN[6:4], DIN[2]};
            6'h20:          shadow_wr.ctrl20 = DIN;
            default:        mapped = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            write_q  <= 1'b0;
            update_q <= 1'b0;
            shadow   <= '0;
            active   <= '0;
            WR_CNT   <= '0;
            ADDR_ERR <= 1'b0;
            UPD_DONE <= 1'b0;
        end else begin
            write_q  <= WRITE;
            update_q <= UPDATE;
            UPD_DONE <= upd_ok;
            ADDR_ERR <= DDS_RST ? 1'b0 : (wr_evt & ~mapped & ~clr) | ADDR_ERR;
            if (clr) begin
                shadow <= '0;
                active <= '0;
                WR_CNT <= '0;
            end else begin
                if (upd_ok) active <= shadow;
                if (wr_ok) shadow <= shadow_wr;
                WR_CNT <= upd_ok ? CNT_W'(wr_ok) : (wr_ok & ~&WR_CNT) ? WR_CNT + CNT_W'(1) : WR_CNT;
            end
        end

    assign FTW1     = active.ftw1;
    assign FTW2     = active.ftw2;
    assign PTW1     = active.ptw1;
    assign PTW2     = active.ptw2;
    assign DFW      = active.dfw;
    assign RAMPRATE = active.ramp;
    assign MODE     = active.mode;
    assign TRIANGLE = active.triangle;
    assign PLLRANGE = active.pllrange;
    assign PLLEN    = active.pllen;
    assign CLKMULT  = active.clkmult;
    assign CTRL20   = active.ctrl20;
endmodule
